logica_activacion_multizona: RTL and testbench
==============================================

// Module: logica_activacion_multizona
// PURPOSE
//  Per-zone alarm/ventilation activation for N cabin zones. Consumes per-zone weak/strong alert flags,
//  synchronised presence per zone and a global ignition. Registers decisions on the Activar_Decidir strobe.
//  Adds a ventilation purge-hold timer per zone. Feeds the alarm/vent drivers and the central control FSM.
// PARAMETERS
//  N_ZONAS   4   number of independent zones (>=1)
//  HOLD_CYC  8   clk cycles ventilation (and alarm) stay on after strong alert clears; 0 = no hold
// PORTS
//  clk              in   1          system clock
//  rst              in   1          reset, asynchronous, active-high
//  alerta           in   2*N_ZONAS  zone i: [2i+1]=weak, [2i]=strong
//  presencia        in   N_ZONAS    synchronised presence per zone
//  ignicion         in   1          synchronised global ignition
//  activar_decidir  in   1          decision strobe, one clk wide
//  ack              in   N_ZONAS    operator silence request per zone (used only with LOGICA_SILENCIO_EN)
//  alarma           out  N_ZONAS    alarm enable per zone, registered
//  ventilacion      out  N_ZONAS    ventilation enable per zone, registered
//  peligro          out  1          combinational OR of all zone requests
// BEHAVIOUR
//  Request per zone: en_i = ~ignicion & presencia[i]
//    req_alarm_i = en_i & (weak_i | strong_i); req_vent_i = en_i & strong_i
//  peligro = OR over i of (req_alarm_i | req_vent_i). Pure combinational, independent of the strobe.
//  Per-zone FSM, rst -> APAGADO, hold counter = 0:
//    APAGADO : alarma=0 ventilacion=0
//    ALERTA  : alarma=1 ventilacion=0
//    VENTILAR: alarma=1 ventilacion=1
//    PURGA   : alarma=1 ventilacion=1; counter decrements every clk
//  Transitions when activar_decidir=1. Priority top-down:
//    ignicion=1                        -> APAGADO from any state; counter cleared (bypasses PURGA)
//    req_vent_i                        -> VENTILAR; counter cleared
//    req_alarm_i & ~req_vent_i:
//      APAGADO/ALERTA                  -> ALERTA
//      VENTILAR                        -> PURGA, counter loaded with HOLD_CYC
//      PURGA                           -> stays in PURGA
//    no request:
//      ALERTA                          -> APAGADO
//      VENTILAR                        -> PURGA, counter loaded with HOLD_CYC
//      PURGA                           -> stays in PURGA
//  PURGA exit: on the clk where counter=1 and decrements to 0, next state APAGADO, regardless of strobe,
//    unless that same clk has a strobe with req_vent_i (-> VENTILAR) or ignicion (-> APAGADO).
//  HOLD_CYC=0: VENTILAR with req_vent_i=0 goes directly to ALERTA (weak present) or APAGADO.
//  Latency: outputs change on the clk edge that samples the strobe (1 cycle).
//  Without a strobe, state holds except the PURGA countdown.
//  Counter width: $clog2(HOLD_CYC+1), min 1. Never wraps; saturates at 0.
//  Zones are fully independent except for the shared ignicion and strobe.
//  rst asserted mid-PURGA or at any time: immediate APAGADO, all outputs 0, counters 0.
// CONFIGURATION
//  LOGICA_SILENCIO_EN defined:
//    - Per-zone silenced flag. ack[i]=1 in ALERTA/VENTILAR/PURGA sets the flag (any clk, no strobe needed).
//    - While the flag is set: alarma[i]=0; ventilacion[i] unaffected.
//    - Flag clears on entry to APAGADO and on rst.
//    - ack in APAGADO is ignored.
//  LOGICA_SILENCIO_EN undefined: ack ignored; alarma follows the FSM table only.
// TESTING
//  T1 reset: rst=1 with random inputs -> alarma=0, ventilacion=0; peligro follows inputs.
//  T2 weak: N=4, presencia=4'b0010, zone1 weak, strobe -> next clk alarma=0010, ventilacion=0000.
//  T3 purge: zone2 strong, strobe -> alarma[2]=ventilacion[2]=1;
//     clear strong, strobe -> both stay 1 for exactly 8 clks, then 0.
//  T4 ignition: ignicion=1 + strobe mid-PURGA -> all outputs 0 next clk; peligro=0 same cycle.
//  T5 no strobe: alerta toggles with activar_decidir=0 -> outputs unchanged; peligro tracks combinationally.
//  T6 silence (macro on): zone0 VENTILAR, ack[0] pulse -> alarma[0]=0, ventilacion[0]=1;
//     after return to APAGADO, new weak + strobe -> alarma[0]=1.

Source files
------------

// File: rtl/logica_activacion_multizona.sv
// Per-zone alarm/ventilation activation with purge-hold timer, decided on the activar_decidir strobe.
// Optional operator silence per zone is enabled by defining LOGICA_SILENCIO_EN.
module logica_activacion_multizona #(
    parameter int N_ZONAS  = 4,
    parameter int HOLD_CYC = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*N_ZONAS-1:0]   alerta,
    input  logic [N_ZONAS-1:0]     presencia,
    input  logic                   ignicion,
    input  logic                   activar_decidir,
    input  logic [N_ZONAS-1:0]     ack,
    output logic [N_ZONAS-1:0]     alarma,
    output logic [N_ZONAS-1:0]     ventilacion,
    output logic                   peligro
);

    localparam int CW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

    typedef enum logic [1:0] {
        APAGADO  = 2'd0,
        ALERTA   = 2'd1,
        VENTILAR = 2'd2,
        PURGA    = 2'd3
    } estado_t;

    estado_t              estado_q [N_ZONAS];
    estado_t              estado_d [N_ZONAS];
    logic [CW-1:0]        cnt_q    [N_ZONAS];
    logic [CW-1:0]        cnt_d    [N_ZONAS];
    logic [N_ZONAS-1:0]   sil_q, sil_d;
    logic [N_ZONAS-1:0]   alarma_q, alarma_d;
    logic [N_ZONAS-1:0]   ventilacion_q, ventilacion_d;
    logic [N_ZONAS-1:0]   req_alarm, req_vent;

`ifndef LOGICA_SILENCIO_EN
    logic unused_ack;
    assign unused_ack = ^ack;
`endif

    always_comb begin
        req_alarm = '0;
        req_vent  = '0;
        for (int unsigned i = 0; i < N_ZONAS; i++) begin
            req_alarm[i] = ~ignicion & presencia[i] & (alerta[2*i+1] | alerta[2*i]);
            req_vent[i]  = ~ignicion & presencia[i] & alerta[2*i];
        end
        peligro = |(req_alarm | req_vent);
    end

    always_comb begin
        sil_d         = '0;
        alarma_d      = '0;
        ventilacion_d = '0;
        for (int unsigned i = 0; i < N_ZONAS; i++) begin
            estado_d[i] = estado_q[i];
            cnt_d[i]    = cnt_q[i];

            // Countdown runs every clk; the strobe may override its result below.
            if (estado_q[i] == PURGA) begin
                if (cnt_q[i] <= CW'(1)) begin
                    estado_d[i] = APAGADO;
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end
            end

            if (activar_decidir) begin
                if (ignicion) begin
                    estado_d[i] = APAGADO;
                    cnt_d[i]    = '0;
                end else if (req_vent[i]) begin
                    estado_d[i] = VENTILAR;
                    cnt_d[i]    = '0;
                end else begin
                    case (estado_q[i])
                        APAGADO, ALERTA: estado_d[i] = req_alarm[i] ? ALERTA : APAGADO;
                        VENTILAR: begin
                            if (HOLD_CYC > 0) begin
                                estado_d[i] = PURGA;
                                cnt_d[i]    = CW'(HOLD_CYC);
                            end else begin
                                estado_d[i] = req_alarm[i] ? ALERTA : APAGADO;
                            end
                        end
                        default: ;
                    endcase
                end
            end

`ifdef LOGICA_SILENCIO_EN
            if (estado_d[i] == APAGADO)
                sil_d[i] = 1'b0;
            else
                sil_d[i] = sil_q[i] | (ack[i] & (estado_q[i] != APAGADO));
`endif
            alarma_d[i]      = (estado_d[i] != APAGADO) & ~sil_d[i];
            ventilacion_d[i] = (estado_d[i] == VENTILAR) | (estado_d[i] == PURGA);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_ZONAS; i++) begin
                estado_q[i] <= APAGADO;
                cnt_q[i]    <= '0;
            end
            sil_q         <= '0;
            alarma_q      <= '0;
            ventilacion_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_ZONAS; i++) begin
                estado_q[i] <= estado_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            sil_q         <= sil_d;
            alarma_q      <= alarma_d;
            ventilacion_q <= ventilacion_d;
        end
    end

    assign alarma      = alarma_q;
    assign ventilacion = ventilacion_q;

endmodule

// File: tb/tb_logica_activacion_multizona.sv
// Bench for logica_activacion_multizona: directed vector table, purge/ignition sequences and
// randomized traffic against a behavioural zone model.
module tb_logica_activacion_multizona;

    localparam int N    = 4;
    localparam int HOLD = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [2*N-1:0] alerta = '0;
    logic [N-1:0]   presencia = '0;
    logic           ignicion = 1'b0;
    logic           activar_decidir = 1'b0;
    logic [N-1:0]   ack = '0;
    logic [N-1:0]   alarma, ventilacion;
    logic           peligro;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: raw alarm/vent flags plus remaining purge cycles per zone.
    bit m_alarm [N];
    bit m_vent  [N];
    int m_hold  [N];
    bit m_sil   [N];

    logica_activacion_multizona #(.N_ZONAS(N), .HOLD_CYC(HOLD)) dut (
        .clk(clk), .rst(rst), .alerta(alerta), .presencia(presencia), .ignicion(ignicion),
        .activar_decidir(activar_decidir), .ack(ack), .alarma(alarma),
        .ventilacion(ventilacion), .peligro(peligro)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*N-1:0] al;
        logic [N-1:0]   pr;
        logic           ig;
        logic           st;
        logic [N-1:0]   exp_alarma;
        logic [N-1:0]   exp_vent;
        logic           exp_peligro;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_peligro();
        logic p = 1'b0;
        for (int i = 0; i < N; i++)
            if (!ignicion && presencia[i] && (alerta[2*i] || alerta[2*i+1])) p = 1'b1;
        return p;
    endfunction

    function automatic logic [N-1:0] model_alarma();
        logic [N-1:0] a;
        for (int i = 0; i < N; i++) a[i] = m_alarm[i] && !m_sil[i];
        return a;
    endfunction

    function automatic logic [N-1:0] model_vent();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_vent[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_alarm[i] = 0; m_vent[i] = 0; m_hold[i] = 0; m_sil[i] = 0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < N; i++) begin
            bit en, ra, rv, prev_on;
            en = !ignicion && presencia[i];
            ra = en && (alerta[2*i] || alerta[2*i+1]);
            rv = en && alerta[2*i];
            prev_on = m_alarm[i];
            if (activar_decidir && ignicion) begin
                m_alarm[i] = 0; m_vent[i] = 0; m_hold[i] = 0;
            end else if (activar_decidir && rv) begin
                m_alarm[i] = 1; m_vent[i] = 1; m_hold[i] = 0;
            end else if (m_hold[i] > 0) begin
                m_hold[i]--;
                if (m_hold[i] == 0) begin m_alarm[i] = 0; m_vent[i] = 0; end
            end else if (activar_decidir && m_vent[i]) begin
                if (HOLD > 0) m_hold[i] = HOLD;
                else begin m_vent[i] = 0; m_alarm[i] = ra; end
            end else if (activar_decidir) begin
                m_alarm[i] = ra;
            end
`ifdef LOGICA_SILENCIO_EN
            if (!m_alarm[i]) m_sil[i] = 0;
            else if (ack[i] && prev_on) m_sil[i] = 1;
`endif
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        alerta = 8'($urandom); presencia = 4'($urandom); ignicion = 1'($urandom);
        activar_decidir = 1'($urandom); ack = 4'($urandom);
        #1;
        chk("rst_alarma", 32'(alarma), 32'h0);
        chk("rst_vent", 32'(ventilacion), 32'h0);
        chk("rst_peligro", 32'(peligro), 32'(model_peligro()));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        activar_decidir = 1'b0; ack = '0;
    endtask

    // One clk of stimulus checked against the model.
    task automatic step(input logic [2*N-1:0] al, input logic [N-1:0] pr, input logic ig,
                        input logic st, input logic [N-1:0] ak, input string tag);
        @(negedge clk);
        alerta = al; presencia = pr; ignicion = ig; activar_decidir = st; ack = ak;
        #1 chk({tag, "_peligro"}, 32'(peligro), 32'(model_peligro()));
        @(posedge clk);
        model_update();
        #1;
        chk({tag, "_alarma"}, 32'(alarma), 32'(model_alarma()));
        chk({tag, "_vent"}, 32'(ventilacion), 32'(model_vent()));
    endtask

    vec_t vt [8];
    int   hold_cnt;

    initial begin
        vt[0] = '{8'h08, 4'b0010, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b1};
        vt[1] = '{8'h08, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1};
        vt[2] = '{8'h00, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b0};
        vt[3] = '{8'h00, 4'b0010, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0};
        vt[4] = '{8'h10, 4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0100, 1'b1};
        vt[5] = '{8'h00, 4'b0100, 1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0};
        vt[6] = '{8'h10, 4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0100, 1'b0};
        vt[7] = '{8'h10, 4'b0100, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0};

        do_reset();

        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            alerta = vt[k].al; presencia = vt[k].pr; ignicion = vt[k].ig;
            activar_decidir = vt[k].st; ack = '0;
            #1 chk($sformatf("vec%0d_peligro", k), 32'(peligro), 32'(vt[k].exp_peligro));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_alarma", k), 32'(alarma), 32'(vt[k].exp_alarma));
            chk($sformatf("vec%0d_vent", k), 32'(ventilacion), 32'(vt[k].exp_vent));
        end

        // Purge hold: outputs must stay on for exactly HOLD clocks after the clearing strobe.
        do_reset();
        step(8'h10, 4'b0100, 1'b0, 1'b1, 4'b0000, "purge_on");
        step(8'h00, 4'b0100, 1'b0, 1'b1, 4'b0000, "purge_clr");
        hold_cnt = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            activar_decidir = 1'b0;
            @(posedge clk);
            #1;
            if (ventilacion[2] !== 1'b1) break;
            hold_cnt++;
        end
        chk("purge_len", 32'(hold_cnt), 32'(HOLD));
        chk("purge_end_alarma", 32'(alarma), 32'h0);

        // Strobe with alarm-only request during purge does not restart the hold.
        do_reset();
        step(8'h10, 4'b0100, 1'b0, 1'b1, 4'b0000, "pw_on");
        step(8'h00, 4'b0100, 1'b0, 1'b1, 4'b0000, "pw_clr");
        for (int c = 0; c < HOLD; c++)
            step(8'h20, 4'b0100, 1'b0, 1'b1, 4'b0000, $sformatf("pw_weak%0d", c));

`ifdef LOGICA_SILENCIO_EN
        do_reset();
        step(8'h01, 4'b0001, 1'b0, 1'b1, 4'b0000, "sil_vent");
        step(8'h01, 4'b0001, 1'b0, 1'b0, 4'b0001, "sil_ack");
        chk("sil_ack_alarma0", 32'(alarma[0]), 32'h0);
        chk("sil_ack_vent0", 32'(ventilacion[0]), 32'h1);
        step(8'h00, 4'b0001, 1'b0, 1'b1, 4'b0000, "sil_clr");
        for (int c = 0; c < HOLD; c++)
            step(8'h00, 4'b0001, 1'b0, 1'b0, 4'b0000, "sil_hold");
        step(8'h02, 4'b0001, 1'b0, 1'b1, 4'b0000, "sil_new");
        chk("sil_new_alarma0", 32'(alarma[0]), 32'h1);
`endif

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                logic [N-1:0] ak;
                for (int i = 0; i < N; i++) ak[i] = ($urandom_range(0, 9) == 0);
                step(8'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 2) == 0), ak, "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
